// File: rtl/tone_sequencer.sv
// tone_sequencer: drives the FSK phase accumulator from a host-programmed
// table of four 16-bit phase increments plus a symbol length.
// Each accepted 2-bit symbol writes the chosen increment to the accumulator's
// shared 8-bit bus (divf low byte, then divr high byte). It then enables the
// accumulator for exactly sym_len cycles.
// Optional build macro TONE_SEQ_SKIP_RELOAD_EN: a symbol that repeats the
// tone already loaded skips both load cycles and keeps acc_en high, so the
// repeated tone stays phase-continuous.
module tone_sequencer #(
    parameter int NUM_TONES = 4,
    parameter int SYM_LEN_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       sym_valid,
    input  logic [1:0] sym_data,
    output logic       sym_ready,
    output logic       sym_done,
    output logic       busy,
    output logic [7:0] acc_data,
    output logic       acc_wr_divf,
    output logic       acc_wr_divr,
    output logic       acc_en
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_F = 2'd1,
        LOAD_R = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [SYM_LEN_W-1:0] LEN_ONE = SYM_LEN_W'(1);
    localparam logic [SYM_LEN_W-1:0] LEN_TWO = SYM_LEN_W'(2);

    // Host-visible configuration
    logic [7:0]           tone_lo [NUM_TONES];
    logic [7:0]           tone_hi [NUM_TONES];
    logic [SYM_LEN_W-1:0] sym_len;

    // Per-symbol state captured at accept time
    state_t               state;
    logic [7:0]           shadow_hi;
    logic [SYM_LEN_W-1:0] shadow_len;
    logic [SYM_LEN_W-1:0] count;

    logic                 accept;
    logic [15:0]          sel_tone;
    logic                 skip_reload;

    assign accept   = sym_valid && sym_ready;
    assign sel_tone = {tone_hi[sym_data], tone_lo[sym_data]};

    // A programmed length of zero still runs the accumulator for one cycle.
    function automatic logic [SYM_LEN_W-1:0] eff_len(input logic [SYM_LEN_W-1:0] len);
        return (len == '0) ? LEN_ONE : len;
    endfunction

`ifdef TONE_SEQ_SKIP_RELOAD_EN
    logic [15:0] loaded_tone;

    assign skip_reload = (sel_tone == loaded_tone);
`else
    assign skip_reload = 1'b0;
`endif

    // Config byte writes land one cycle later regardless of sequencer state;
    // addresses 10-15 are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TONES; i++) begin
                tone_lo[i] <= '0;
                tone_hi[i] <= '0;
            end
            sym_len <= LEN_ONE;
        end else if (cfg_wr) begin
            if (!cfg_addr[3]) begin
                if (cfg_addr[0]) begin
                    tone_hi[cfg_addr[2:1]] <= cfg_data;
                end else begin
                    tone_lo[cfg_addr[2:1]] <= cfg_data;
                end
            end else if (cfg_addr == 4'd8) begin
                sym_len[7:0] <= cfg_data;
            end else if (cfg_addr == 4'd9) begin
                sym_len[SYM_LEN_W-1:8] <= cfg_data[SYM_LEN_W-9:0];
            end
        end
    end

    // Sequencer FSM; every output is computed for the state being entered so
    // that it appears registered in the same cycle as that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shadow_hi   <= '0;
            shadow_len  <= '0;
            count       <= '0;
            sym_ready   <= 1'b0;
            sym_done    <= 1'b0;
            busy        <= 1'b0;
            acc_data    <= '0;
            acc_wr_divf <= 1'b0;
            acc_wr_divr <= 1'b0;
            acc_en      <= 1'b0;
`ifdef TONE_SEQ_SKIP_RELOAD_EN
            loaded_tone <= '0;
`endif
        end else begin
            acc_wr_divf <= 1'b0;
            acc_wr_divr <= 1'b0;
            acc_data    <= '0;
            sym_done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= LOAD_F;
                        shadow_hi   <= sel_tone[15:8];
                        shadow_len  <= sym_len;
                        acc_data    <= sel_tone[7:0];
                        acc_wr_divf <= 1'b1;
                        acc_en      <= 1'b0;
                        sym_ready   <= 1'b0;
                        busy        <= 1'b1;
`ifdef TONE_SEQ_SKIP_RELOAD_EN
                        loaded_tone <= sel_tone;
`endif
                    end else begin
                        acc_en    <= 1'b0;
                        sym_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                LOAD_F: begin
                    state       <= LOAD_R;
                    acc_data    <= shadow_hi;
                    acc_wr_divr <= 1'b1;
                    busy        <= 1'b1;
                end

                LOAD_R: begin
                    state     <= RUN;
                    count     <= eff_len(shadow_len);
                    acc_en    <= 1'b1;
                    sym_ready <= (eff_len(shadow_len) == LEN_ONE);
                    sym_done  <= (eff_len(shadow_len) == LEN_ONE);
                    busy      <= 1'b1;
                end

                RUN: begin
                    if (count != LEN_ONE) begin
                        count     <= count - LEN_ONE;
                        sym_ready <= (count == LEN_TWO);
                        sym_done  <= (count == LEN_TWO);
                    end else if (accept && skip_reload) begin
                        count     <= eff_len(sym_len);
                        acc_en    <= 1'b1;
                        sym_ready <= (eff_len(sym_len) == LEN_ONE);
                        sym_done  <= (eff_len(sym_len) == LEN_ONE);
                    end else if (accept) begin
                        state       <= LOAD_F;
                        shadow_hi   <= sel_tone[15:8];
                        shadow_len  <= sym_len;
                        count       <= '0;
                        acc_data    <= sel_tone[7:0];
                        acc_wr_divf <= 1'b1;
                        acc_en      <= 1'b0;
                        sym_ready   <= 1'b0;
`ifdef TONE_SEQ_SKIP_RELOAD_EN
                        loaded_tone <= sel_tone;
`endif
                    end else begin
                        state     <= IDLE;
                        count     <= '0;
                        acc_en    <= 1'b0;
                        sym_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    acc_en    <= 1'b0;
                    sym_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed self-checking bench for tone_sequencer.
// Mirrors TONE_SEQ_SKIP_RELOAD_EN so the repeat-tone scenario expects the
// behaviour of whichever build is compiled.
module tb_tone_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_wr;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic       sym_done;
    logic       busy;
    logic [7:0] acc_data;
    logic       acc_wr_divf;
    logic       acc_wr_divr;
    logic       acc_en;

    int tests_run;
    int tests_failed;

    // Packed view: {divf, divr, en, ready, done, busy, data[7:0]}
    logic [13:0] obs;
    assign obs = {acc_wr_divf, acc_wr_divr, acc_en, sym_ready, sym_done, busy, acc_data};

    tone_sequencer #(.NUM_TONES(4), .SYM_LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_ready   (sym_ready),
        .sym_done    (sym_done),
        .busy        (busy),
        .acc_data    (acc_data),
        .acc_wr_divf (acc_wr_divf),
        .acc_wr_divr (acc_wr_divr),
        .acc_en      (acc_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (obs !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 14'h0);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (sym_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_ready: got ready=%b busy=%b expected ready=1 busy=0", sym_ready, busy);
        end
        // Start a long symbol and pull reset in the middle of RUN.
        cfg_write(4'd8, 8'd10);
        cfg_write(4'd4, 8'h11);
        sym_valid = 1'b1;
        sym_data  = 2'd2;
        tick();
        sym_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (acc_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_pre_run: got acc_en=%b expected 1", acc_en);
        end
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (obs !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_run: got %h expected %h", obs, 14'h0);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (sym_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready_after: got %b expected 1", sym_ready);
        end
        // Table and length are back to defaults: tone 0x0000, length 1.
        sym_valid = 1'b1;
        sym_data  = 2'd2;
        tick();
        sym_valid = 1'b0;
        tests_run++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL reset_table_cleared: got %h expected %h", obs, {1'b1, 5'b00001, 8'h00});
        end
        tick();
        tick();
        tests_run++;
        if (acc_en !== 1'b1 || sym_done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_len_one_run: got en=%b done=%b expected en=1 done=1", acc_en, sym_done);
        end
        tick();
        tests_run++;
        if (acc_en !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_len_one_end: got en=%b busy=%b expected 0 0", acc_en, busy);
        end
    endtask

    task automatic test_basic;
        logic [13:0] exp;
        cfg_write(4'd4, 8'h7C);
        cfg_write(4'd5, 8'h3A);
        cfg_write(4'd8, 8'd5);
        cfg_write(4'd9, 8'd0);
        sym_valid = 1'b1;
        sym_data  = 2'd2;
        tests_run++;
        if (sym_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_ready_idle: got %b expected 1", sym_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            sym_valid = 1'b0;
            exp = {(k == 1), (k == 2), (k >= 3 && k <= 7), (k == 7 || k == 8),
                   (k == 7), (k <= 7),
                   (k == 1) ? 8'h7C : (k == 2) ? 8'h3A : 8'h00};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL basic cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [13:0] exp;
        cfg_write(4'd0, 8'h02);
        cfg_write(4'd1, 8'h01);
        cfg_write(4'd2, 8'h04);
        cfg_write(4'd3, 8'h03);
        cfg_write(4'd8, 8'd3);
        sym_valid = 1'b1;
        sym_data  = 2'd0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) sym_data = 2'd1;
            if (k == 6) sym_valid = 1'b0;
            exp = {(k == 1 || k == 6), (k == 2 || k == 7),
                   ((k >= 3 && k <= 5) || (k >= 8 && k <= 10)),
                   (k == 5 || k == 10 || k == 11), (k == 5 || k == 10), (k <= 10),
                   (k == 1) ? 8'h02 : (k == 2) ? 8'h01 : (k == 6) ? 8'h04 : (k == 7) ? 8'h03 : 8'h00};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_cfg_overwrite;
        sym_valid = 1'b1;
        sym_data  = 2'd1;
        cfg_wr    = 1'b1;
        cfg_addr  = 4'd2;
        cfg_data  = 8'hAA;
        tick();
        sym_valid = 1'b0;
        cfg_wr    = 1'b0;
        tests_run++;
        if (acc_wr_divf !== 1'b1 || acc_data !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL overwrite_old_byte: got divf=%b data=%h expected 1 04", acc_wr_divf, acc_data);
        end
        for (int k = 2; k <= 6; k++) tick();
        sym_valid = 1'b1;
        sym_data  = 2'd1;
        tick();
        sym_valid = 1'b0;
        tests_run++;
        if (acc_wr_divf !== 1'b1 || acc_data !== 8'hAA) begin
            tests_failed++;
            $display("[TB] FAIL overwrite_new_byte: got divf=%b data=%h expected 1 aa", acc_wr_divf, acc_data);
        end
        tick();
        tests_run++;
        if (acc_wr_divr !== 1'b1 || acc_data !== 8'h03) begin
            tests_failed++;
            $display("[TB] FAIL overwrite_high_byte: got divr=%b data=%h expected 1 03", acc_wr_divr, acc_data);
        end
        for (int k = 3; k <= 6; k++) tick();
    endtask

    task automatic test_len_zero;
        int en_cycles;
        cfg_write(4'd8, 8'd0);
        cfg_write(4'd9, 8'd0);
        sym_valid = 1'b1;
        sym_data  = 2'd0;
        en_cycles = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            sym_valid = 1'b0;
            if (acc_en === 1'b1) en_cycles++;
        end
        tests_run++;
        if (en_cycles != 1) begin
            tests_failed++;
            $display("[TB] FAIL len_zero_en_cycles: got %0d expected 1", en_cycles);
        end
        cfg_write(4'd12, 8'hFF);
        sym_valid = 1'b1;
        sym_data  = 2'd2;
        tick();
        sym_valid = 1'b0;
        tests_run++;
        if (acc_data !== 8'h7C) begin
            tests_failed++;
            $display("[TB] FAIL addr12_tone_lo: got %h expected 7c", acc_data);
        end
        tick();
        tests_run++;
        if (acc_data !== 8'h3A) begin
            tests_failed++;
            $display("[TB] FAIL addr12_tone_hi: got %h expected 3a", acc_data);
        end
        en_cycles = 0;
        for (int k = 3; k <= 8; k++) begin
            tick();
            if (acc_en === 1'b1) en_cycles++;
        end
        tests_run++;
        if (en_cycles != 1) begin
            tests_failed++;
            $display("[TB] FAIL addr12_len: got %0d en cycles expected 1", en_cycles);
        end
    endtask

    task automatic test_skip_reload;
        logic [13:0] exp;
        int          last;
        int          third;
        logic        f, r, en, rdy, dn, bsy;
        logic [7:0]  d;
        cfg_write(4'd6, 8'h66);
        cfg_write(4'd7, 8'h55);
        cfg_write(4'd8, 8'd4);
`ifdef TONE_SEQ_SKIP_RELOAD_EN
        last  = 17;
        third = 10;
`else
        last  = 19;
        third = 12;
`endif
        sym_valid = 1'b1;
        sym_data  = 2'd3;
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == 7) sym_data = 2'd1;
            if (k == third + 1) sym_valid = 1'b0;
`ifdef TONE_SEQ_SKIP_RELOAD_EN
            f   = (k == 1 || k == 11);
            r   = (k == 2 || k == 12);
            en  = (k >= 3 && k <= 10) || (k >= 13 && k <= 16);
            dn  = (k == 6 || k == 10 || k == 16);
            rdy = dn || (k == 17);
            bsy = (k <= 16);
            d   = (k == 1) ? 8'h66 : (k == 2) ? 8'h55 : (k == 11) ? 8'hAA : (k == 12) ? 8'h03 : 8'h00;
`else
            f   = (k == 1 || k == 7 || k == 13);
            r   = (k == 2 || k == 8 || k == 14);
            en  = (k >= 3 && k <= 6) || (k >= 9 && k <= 12) || (k >= 15 && k <= 18);
            dn  = (k == 6 || k == 12 || k == 18);
            rdy = dn || (k == 19);
            bsy = (k <= 18);
            d   = (k == 1 || k == 7) ? 8'h66 : (k == 2 || k == 8) ? 8'h55 :
                  (k == 13) ? 8'hAA : (k == 14) ? 8'h03 : 8'h00;
`endif
            exp = {f, r, en, rdy, dn, bsy, d};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL repeat_tone cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cfg_wr       = 1'b0;
        cfg_addr     = 4'd0;
        cfg_data     = 8'd0;
        sym_valid    = 1'b0;
        sym_data     = 2'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_cfg_overwrite();
        test_len_zero();
        test_skip_reload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
